// File: rtl/cdb_arbiter_pkg.sv
// Shared defaults and source-select encoding for the CDB arbiter slice.
// Also holds the round-robin grant helper used by the arbiter.
package cdb_arbiter_pkg;

  localparam int XLEN_DEF       = 32;
  localparam int RB_W_DEF       = 4;
  localparam int FIFO_DEPTH_DEF = 4;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LSB = 1'b1
  } src_e;

  // On a tie the source that did not win last time gets the bus.
  function automatic src_e pick_src(input logic alu_ne, input logic lsb_ne, input src_e last);
    src_e g;
    if (alu_ne && lsb_ne) begin
      g = (last == SRC_ALU) ? SRC_LSB : SRC_ALU;
    end else if (lsb_ne) begin
      g = SRC_LSB;
    end else begin
      g = SRC_ALU;
    end
    return g;
  endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Result-source and broadcast-bus bundle between producers and the CDB arbiter.
interface cdb_arbiter_if
  import cdb_arbiter_pkg::*;
#(
  parameter int RB_W = RB_W_DEF,
  parameter int XLEN = XLEN_DEF
);

  logic            alu_valid;
  logic [RB_W-1:0] alu_idx;
  logic [XLEN-1:0] alu_val;
  logic            alu_ready;

  logic            lsb_valid;
  logic [RB_W-1:0] lsb_idx;
  logic [XLEN-1:0] lsb_val;
  logic            lsb_ready;

  logic            cdb_valid;
  logic [RB_W-1:0] cdb_idx;
  logic [XLEN-1:0] cdb_val;

  modport master (
    output alu_valid, alu_idx, alu_val, lsb_valid, lsb_idx, lsb_val,
    input  alu_ready, lsb_ready, cdb_valid, cdb_idx, cdb_val
  );

  modport slave (
    input  alu_valid, alu_idx, alu_val, lsb_valid, lsb_idx, lsb_val,
    output alu_ready, lsb_ready, cdb_valid, cdb_idx, cdb_val
  );

endinterface

// File: rtl/cdb_fifo.sv
// Per-source circular result queue: push/pop/flush with registered occupancy count.
// en=0 freezes every register; flush beats push/pop.
module cdb_fifo
  import cdb_arbiter_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEF,
  parameter int RB_W  = RB_W_DEF,
  parameter int XLEN  = XLEN_DEF,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             flush,
  input  logic             push,
  input  logic [RB_W-1:0]  push_idx,
  input  logic [XLEN-1:0]  push_val,
  input  logic             pop,
  output logic [RB_W-1:0]  head_idx,
  output logic [XLEN-1:0]  head_val,
  output logic [CNT_W-1:0] count
);

  localparam int ENT_W = RB_W + XLEN;

  logic [ENT_W-1:0] mem_q [DEPTH];
  logic [ENT_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next-state for storage, pointers and count; pointers wrap naturally at DEPTH.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (en && flush) begin
      wr_ptr_d = {PTR_W{1'b0}};
      rd_ptr_d = {PTR_W{1'b0}};
      cnt_d    = {CNT_W{1'b0}};
    end else if (en) begin
      if (push) begin
        mem_d[wr_ptr_q] = {push_idx, push_val};
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + CNT_W'(1);
        2'b01:   cnt_d = cnt_q - CNT_W'(1);
        default: cnt_d = cnt_q;
      endcase
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Queue state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {ENT_W{1'b0}};
      end
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      cnt_q    <= {CNT_W{1'b0}};
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign {head_idx, head_val} = mem_q[rd_ptr_q];
  assign count                = cnt_q;

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: queues ALU and LSB results and broadcasts one per cycle,
// round-robin on contention, with misprediction flush and a global freeze.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int RB_W       = RB_W_DEF,
  parameter int XLEN       = XLEN_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        jp_wrong,
  cdb_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  logic [CNT_W-1:0] alu_cnt_s, lsb_cnt_s;
  logic [RB_W-1:0]  alu_head_idx_s, lsb_head_idx_s;
  logic [XLEN-1:0]  alu_head_val_s, lsb_head_val_s;
  logic             alu_ready_s, lsb_ready_s;
  logic             alu_push_s, lsb_push_s, alu_pop_s, lsb_pop_s;
  logic             alu_ne_s, lsb_ne_s, flush_s;
  src_e             grant_s;

  logic             cdb_valid_q, cdb_valid_d;
  logic [RB_W-1:0]  cdb_idx_q, cdb_idx_d;
  logic [XLEN-1:0]  cdb_val_q, cdb_val_d;
  src_e             last_grant_q, last_grant_d;

  // Acceptance and arbitration look only at registered counts, so a freed slot
  // is not reusable in the cycle it frees and a new entry waits one edge.
  always_comb begin
    alu_ready_s = (alu_cnt_s < FULL_CNT) && rdy && !jp_wrong;
    lsb_ready_s = (lsb_cnt_s < FULL_CNT) && rdy && !jp_wrong;
    alu_push_s  = bus.alu_valid && alu_ready_s;
    lsb_push_s  = bus.lsb_valid && lsb_ready_s;
    alu_ne_s    = (alu_cnt_s != {CNT_W{1'b0}});
    lsb_ne_s    = (lsb_cnt_s != {CNT_W{1'b0}});
    flush_s     = rdy && jp_wrong;
    grant_s     = pick_src(alu_ne_s, lsb_ne_s, last_grant_q);
    alu_pop_s   = rdy && !jp_wrong && alu_ne_s && (grant_s == SRC_ALU);
    lsb_pop_s   = rdy && !jp_wrong && lsb_ne_s && (grant_s == SRC_LSB);
  end

  // Broadcast register and grant history next-state.
  always_comb begin
    cdb_valid_d  = cdb_valid_q;
    cdb_idx_d    = cdb_idx_q;
    cdb_val_d    = cdb_val_q;
    last_grant_d = last_grant_q;
    if (!rdy) begin
      cdb_valid_d = cdb_valid_q;
    end else if (jp_wrong) begin
      cdb_valid_d = 1'b0;
    end else if (alu_pop_s) begin
      cdb_valid_d  = 1'b1;
      cdb_idx_d    = alu_head_idx_s;
      cdb_val_d    = alu_head_val_s;
      last_grant_d = SRC_ALU;
    end else if (lsb_pop_s) begin
      cdb_valid_d  = 1'b1;
      cdb_idx_d    = lsb_head_idx_s;
      cdb_val_d    = lsb_head_val_s;
      last_grant_d = SRC_LSB;
    end else begin
      cdb_valid_d = 1'b0;
    end
  end

  // Broadcast and grant registers; last_grant resets to LSB so ALU wins the first tie.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cdb_valid_q  <= 1'b0;
      cdb_idx_q    <= {RB_W{1'b0}};
      cdb_val_q    <= {XLEN{1'b0}};
      last_grant_q <= SRC_LSB;
    end else begin
      cdb_valid_q  <= cdb_valid_d;
      cdb_idx_q    <= cdb_idx_d;
      cdb_val_q    <= cdb_val_d;
      last_grant_q <= last_grant_d;
    end
  end

  cdb_fifo #(.DEPTH(FIFO_DEPTH), .RB_W(RB_W), .XLEN(XLEN)) u_alu_fifo (
    .clk      (clk),
    .rst      (rst),
    .en       (rdy),
    .flush    (flush_s),
    .push     (alu_push_s),
    .push_idx (bus.alu_idx),
    .push_val (bus.alu_val),
    .pop      (alu_pop_s),
    .head_idx (alu_head_idx_s),
    .head_val (alu_head_val_s),
    .count    (alu_cnt_s)
  );

  cdb_fifo #(.DEPTH(FIFO_DEPTH), .RB_W(RB_W), .XLEN(XLEN)) u_lsb_fifo (
    .clk      (clk),
    .rst      (rst),
    .en       (rdy),
    .flush    (flush_s),
    .push     (lsb_push_s),
    .push_idx (bus.lsb_idx),
    .push_val (bus.lsb_val),
    .pop      (lsb_pop_s),
    .head_idx (lsb_head_idx_s),
    .head_val (lsb_head_val_s),
    .count    (lsb_cnt_s)
  );

  assign bus.alu_ready = alu_ready_s;
  assign bus.lsb_ready = lsb_ready_s;
  assign bus.cdb_valid = cdb_valid_q;
  assign bus.cdb_idx   = cdb_idx_q;
  assign bus.cdb_val   = cdb_val_q;

endmodule
